// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
// Optional stall-cycle counter is enabled by HAZARD_STALL_CNT_EN.
package hazard_stall_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_BUSY = 2'd1,
      MDU_DONE = 2'd2
   } hsc_state_t;

   localparam int unsigned MDU_CYCLES_DEF = 32;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID instruction
// reads, and forwarding cannot deliver it in time. r0 never hazards.
module load_use_detect (
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic [4:0] ex_rt,
   input  logic       ex_memread,
   output logic       lu
);

   assign lu = ex_memread && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: MDU occupancy, load-use stall, branch flush.
// Define HAZARD_STALL_CNT_EN to add the saturating stall_cycles counter.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int unsigned MDU_CYCLES = MDU_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        id_branch_taken,
   input  logic [4:0]  ex_rt,
   input  logic        ex_memread,
   input  logic        ex_mdu_start,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_write,
   output logic        idex_bubble,
   output logic        exmem_bubble,
   output logic        mdu_busy,
`ifdef HAZARD_STALL_CNT_EN
   output logic [31:0] stall_cycles,
`endif
   output logic        mdu_done
);

   localparam logic [7:0] CNT_INIT = 8'(MDU_CYCLES - 2);

   hsc_state_t state;
   logic [7:0] cnt;
   logic       lu;
   logic       mdu_stall;

   load_use_detect u_lu (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .ex_rt      (ex_rt),
      .ex_memread (ex_memread),
      .lu         (lu)
   );

   // A start seen in MDU_DONE is the finishing op itself, not a new one.
   assign mdu_stall = ((state == RUN) && ex_mdu_start) || (state == MDU_BUSY);

   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      mdu_busy     = 1'b0;
      mdu_done     = 1'b0;
      if (mdu_stall) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_bubble = 1'b1;
         mdu_busy     = 1'b1;
      end else begin
         mdu_done = (state == MDU_DONE);
         if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end else if (id_branch_taken) begin
            ifid_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 8'd0;
      end else begin
         case (state)
            RUN: if (ex_mdu_start) begin
               state <= MDU_BUSY;
               cnt   <= CNT_INIT;
            end
            MDU_BUSY: begin
               if (cnt != 8'd0) cnt <= cnt - 8'd1;
               else             state <= MDU_DONE;
            end
            MDU_DONE: state <= RUN;
            default:  state <= RUN;
         endcase
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)            stall_cycles <= 32'd0;
      else if (!pc_write) stall_cycles <= sat_inc32(stall_cycles);
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: driver pushes model expectations,
// a negedge monitor pops and compares every cycle.
module tb_hazard_stall_ctrl;

   localparam int MC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
   logic        id_uses_rt = 1'b0, id_branch_taken = 1'b0;
   logic        ex_memread = 1'b0, ex_mdu_start = 1'b0;
   logic        pc_write, ifid_write, ifid_flush, idex_write;
   logic        idex_bubble, exmem_bubble, mdu_busy, mdu_done;
   logic [31:0] cnt_obs;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cycles;
   assign cnt_obs = stall_cycles;
`else
   assign cnt_obs = 32'd0;
`endif

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MDU_CYCLES(MC)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_branch_taken(id_branch_taken),
      .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_mdu_start(ex_mdu_start),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_bubble(idex_bubble),
      .exmem_bubble(exmem_bubble), .mdu_busy(mdu_busy),
`ifdef HAZARD_STALL_CNT_EN
      .stall_cycles(stall_cycles),
`endif
      .mdu_done(mdu_done)
   );

   typedef struct packed {
      logic [7:0]  ctl;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Reference model: stall cycles still owed to the MDU op, a pending done cycle,
   // and a plain stall tally.
   int      mdu_left = 0;
   bit      done_now = 1'b0;
   longint  stalls = 0;

   task automatic apply(input bit r, input bit [4:0] rs, input bit [4:0] rt,
                        input bit urt, input bit br, input bit [4:0] ert,
                        input bit mr, input bit ms);
      exp_t e;
      bit   lu, pcw, ifw, ifl, idw, idb, exb, busy, done, done_next;
      @(posedge clk); #1;
      rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_branch_taken = br;
      ex_rt = ert; ex_memread = mr; ex_mdu_start = ms;

      lu = mr && (ert != 0) && ((ert == rs) || (urt && ert == rt));
      {pcw, ifw, idw} = 3'b111;
      {ifl, idb, exb, busy, done} = 5'b0;
      done_next = 1'b0;
      if (mdu_left > 0 || (!done_now && ms)) begin
         {pcw, ifw, idw} = 3'b000;
         exb = 1'b1; busy = 1'b1;
         if (mdu_left > 0) begin
            mdu_left--;
            done_next = (mdu_left == 0);
         end else begin
            mdu_left = MC - 1;
         end
      end else begin
         done = done_now;
         if (lu) begin
            pcw = 1'b0; ifw = 1'b0; idb = 1'b1;
         end else if (br) begin
            ifl = 1'b1;
         end
      end
      e.ctl = {pcw, ifw, ifl, idw, idb, exb, busy, done};
`ifdef HAZARD_STALL_CNT_EN
      e.cnt = 32'(stalls);
`else
      e.cnt = 32'd0;
`endif
      sb_q.push_back(e);

      done_now = done_next;
      if (r) begin
         mdu_left = 0; done_now = 1'b0; stalls = 0;
      end else if (!pcw && stalls < 64'hFFFF_FFFF) begin
         stalls++;
      end
   endtask

   task automatic idle();
      apply(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
   endtask

   function automatic bit [4:0] rnd_reg();
      case ($urandom_range(0, 3))
         0: return 5'd0;
         1: return 5'd5;
         2: return 5'd7;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e, g;
         e = sb_q.pop_front();
         g.ctl = {pc_write, ifid_write, ifid_flush, idex_write,
                  idex_bubble, exmem_bubble, mdu_busy, mdu_done};
         g.cnt = cnt_obs;
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL vec%0d ctl/cnt: got %b/%0d want %b/%0d",
                     vectors, g.ctl, g.cnt, e.ctl, e.cnt);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      // reset state, idle inputs
      idle();
      // load-use on rs, then cleared
      apply(0, 5'd5, 5'd0, 0, 0, 5'd5, 1, 0);
      idle();
      // r0 never hazards; rt ignored when not used
      apply(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0);
      apply(0, 5'd0, 5'd7, 0, 0, 5'd7, 1, 0);
      apply(0, 5'd1, 5'd7, 1, 0, 5'd7, 1, 0);
      // MDU op with start held through done
      repeat (MC + 1) apply(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
      idle();
      idle();
      // load-use beats branch, branch alone flushes next cycle
      apply(0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0);
      apply(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0);
      // reset in the 2nd busy cycle abandons the op
      apply(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
      apply(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
      apply(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
      repeat (MC + 2) idle();
      // load-use and back-to-back start during the done cycle
      repeat (MC) apply(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
      apply(0, 5'd3, 5'd0, 0, 1, 5'd3, 1, 1);
      apply(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
      repeat (MC + 1) idle();
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         apply($urandom_range(0, 49) == 0, rnd_reg(), rnd_reg(),
               1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, rnd_reg(),
               1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      end
      @(negedge clk); #1;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, vectors %0d", vectors);
      $fatal(1);
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the five-stage core: decides each cycle whether IF/ID/EX advance, stall, bubble or flush. Covers load-use hazards the forwarding unit cannot resolve, taken-branch flush of the fetched instruction, and multi-cycle occupancy of EX by iterative multiply/divide (MDU) operations. It sits beside the ID and EX stages and drives the PC and pipeline-register enable/clear inputs.

## Interface
- MDU_CYCLES, 32, stall cycles per MDU op; legal range 2..256.
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  rs of instruction in ID.
- id_rt  in  5  rt of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- id_branch_taken  in  1  branch in ID resolved taken this cycle.
- ex_rt  in  5  rt (load destination) of instruction in EX.
- ex_memread  in  1  EX instruction is a load (ctr_m read bit).
- ex_mdu_start  in  1  EX holds an MDU op.
- pc_write  out  1  PC may update.
- ifid_write  out  1  IF/ID register may load.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_write  out  1  ID/EX register may load.
- idex_bubble  out  1  load NOP controls into ID/EX.
- exmem_bubble  out  1  load NOP controls into EX/MEM.
- mdu_busy  out  1  MDU op in progress.
- mdu_done  out  1  MDU result valid; EX/MEM captures it this cycle.
- stall_cycles  out  32  stall-cycle count (only with HAZARD_STALL_CNT_EN).

## Operation
- FSM states: RUN, MDU_BUSY, MDU_DONE; 8-bit down-counter cnt.
- Load-use hit (lu): ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Outputs are Mealy, priority MDU > load-use > branch > normal:
  - RUN & ex_mdu_start, or MDU_BUSY: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1, mdu_busy=1, idex_bubble=0, ifid_flush=0.
  - RUN & lu: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, ifid_flush=0.
  - RUN & id_branch_taken: ifid_flush=1, others normal.
  - Normal (RUN or MDU_DONE): pc_write=ifid_write=idex_write=1, all bubbles/flush/mdu_busy 0.
  - MDU_DONE additionally: mdu_done=1; lu and id_branch_taken evaluated as in RUN.
- Transitions: RUN→MDU_BUSY on ex_mdu_start, cnt<=MDU_CYCLES-2. MDU_BUSY: cnt!=0 → cnt-1, stay; cnt==0 → MDU_DONE. MDU_DONE→RUN unconditionally.
- ex_mdu_start ignored in MDU_BUSY and MDU_DONE (same instruction still in EX).
- Load-use with taken branch in same cycle: stall wins, flush suppressed; branch re-evaluated next cycle.
- Load-use needs no state: bubble moves load to MEM, lu drops next cycle.

## Timing
- Reset (cycle after rst high): state RUN, cnt=0, stall_cycles=0; with inputs idle outputs are pc_write=ifid_write=idex_write=1, all others 0.
- rst mid-MDU op: abandons op, RUN next cycle, no mdu_done.
- Load-use: exactly 1 stall cycle, combinational same cycle.
- MDU op: occupies EX MDU_CYCLES+1 cycles; MDU_CYCLES stall cycles (start + MDU_CYCLES-1 busy), then 1 MDU_DONE cycle with mdu_done=1.
- Back-to-back MDU ops: second starts in the cycle after MDU_DONE.

## Configuration
- HAZARD_STALL_CNT_EN defined: stall_cycles increments by 1 each cycle pc_write==0 and rst==0, saturates at 32'hFFFF_FFFF.
- Not defined: port and counter absent; no other behavioural change.

## Structure
- Shared package/macros.v: FSM state encodings (RUN=2'd0, MDU_BUSY=2'd1, MDU_DONE=2'd2), MDU_CYCLES default.
- One sub-module: load_use_detect (combinational lu compare); FSM, counter and output priority in top.

## Test plan
- ex_memread=1, ex_rt=5, id_rs=5 → 1 cycle pc_write=0, idex_bubble=1; next cycle (ex_memread=0) normal.
- ex_memread=1, ex_rt=0, id_rs=0 → no stall; ex_rt=7, id_rt=7, id_uses_rt=0 → no stall.
- MDU_CYCLES=4, ex_mdu_start held → 4 cycles mdu_busy=1, idex_write=0, then 1 cycle mdu_done=1, then RUN.
- lu and id_branch_taken both high → ifid_flush=0, idex_bubble=1; branch alone next cycle → ifid_flush=1.
- rst pulsed in 2nd MDU_BUSY cycle → RUN next cycle, mdu_done never asserts, outputs at reset values.
- HAZARD_STALL_CNT_EN: one load-use + one MDU op (MDU_CYCLES=4) → stall_cycles=5.
